// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Each execution unit parks one result in a
// holding buffer. Every cycle one buffered result is chosen and broadcast
// from an output register. Compare/branch (index 0) has fixed priority,
// the remaining units share the bus round-robin, and a per-buffer age
// counter lets a starving low-priority result override index 0.
module cdb_arbiter #(
    parameter int NUM_REQ      = 5,
    parameter int DATA_W       = 32,
    parameter int ROB_IDX_W    = 6,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    input  logic                         flush,
    input  logic [TAG_W-1:0]             flush_mask,
    output logic                         cdb_valid,
    output logic [DATA_W-1:0]            cdb_data,
    output logic [ROB_IDX_W-1:0]         cdb_rob,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [$clog2(NUM_REQ)-1:0]   cdb_src
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [NUM_REQ-1:0]   r_occ;
    logic [DATA_W-1:0]    r_bufData [NUM_REQ];
    logic [ROB_IDX_W-1:0] r_bufRob  [NUM_REQ];
    logic [TAG_W-1:0]     r_bufTag  [NUM_REQ];
    logic [AGE_W-1:0]     r_age     [1:NUM_REQ-1];
    logic [SRC_W-1:0]     r_rrPtr;

    logic                 r_cdbValid;
    logic [DATA_W-1:0]    r_cdbData;
    logic [ROB_IDX_W-1:0] r_cdbRob;
    logic [TAG_W-1:0]     r_cdbTag;
    logic [SRC_W-1:0]     r_cdbSrc;

    logic [NUM_REQ-1:0]   w_live;
    logic [NUM_REQ-1:0]   w_inKill;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   w_accept;
    logic                 w_starveHit;
    logic                 w_rrHit;
    logic                 w_anyGrant;
    logic [SRC_W-1:0]     w_starveIdx;
    logic [SRC_W-1:0]     w_rrIdx;
    logic [SRC_W-1:0]     w_grantIdx;

    // k-th low-priority index visited when scanning upward from ptr, wrapping
    // from the last requester back to 1 so index 0 is never part of the scan.
    function automatic logic [SRC_W-1:0] rrIndex(input logic [SRC_W-1:0] ptr, input int k);
        int v;
        v = ((int'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1;
        return SRC_W'(v);
    endfunction

    // A buffer is live unless its tag is being squashed this cycle; incoming
    // results carrying a squashed tag are marked so they are dropped on accept.
    always_comb begin
        w_live   = '0;
        w_inKill = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_live[i]   = r_occ[i] && !(flush && (|(r_bufTag[i] & flush_mask)));
            w_inKill[i] = flush && (|(req_tag[i*TAG_W +: TAG_W] & flush_mask));
        end
    end

    // Find the lowest starved low-priority buffer and the round-robin candidate.
    always_comb begin
        w_starveHit = 1'b0;
        w_starveIdx = '0;
        w_rrHit     = 1'b0;
        w_rrIdx     = '0;
        for (int j = NUM_REQ - 1; j >= 1; j--) begin
            if (w_live[j] && (r_age[j] == AGE_MAX)) begin
                w_starveHit = 1'b1;
                w_starveIdx = SRC_W'(j);
            end
        end
        for (int k = NUM_REQ - 2; k >= 0; k--) begin
            if (w_live[rrIndex(r_rrPtr, k)]) begin
                w_rrHit = 1'b1;
                w_rrIdx = rrIndex(r_rrPtr, k);
            end
        end
    end

    // Final pick: starvation override, then branch port, then round-robin.
    always_comb begin
        w_anyGrant = 1'b1;
        w_grantIdx = '0;
        w_grant    = '0;
        if (w_starveHit) begin
            w_grantIdx = w_starveIdx;
        end else if (w_live[0]) begin
            w_grantIdx = '0;
        end else if (w_rrHit) begin
            w_grantIdx = w_rrIdx;
        end else begin
            w_anyGrant = 1'b0;
        end
        if (w_anyGrant) begin
            w_grant[w_grantIdx] = 1'b1;
        end
    end

    assign req_ready = ~r_occ | w_grant;
    assign w_accept  = req_valid & req_ready;

    // Occupancy, aging, round-robin pointer and the broadcast register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= '0;
            r_rrPtr    <= SRC_W'(1);
            r_cdbValid <= 1'b0;
            r_cdbData  <= '0;
            r_cdbRob   <= '0;
            r_cdbTag   <= '0;
            r_cdbSrc   <= '0;
            for (int j = 1; j < NUM_REQ; j++) begin
                r_age[j] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i]) begin
                    r_occ[i] <= !w_inKill[i];
                end else if (w_grant[i]) begin
                    r_occ[i] <= 1'b0;
                end else begin
                    r_occ[i] <= w_live[i];
                end
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (w_grant[j] || !w_live[j]) begin
                    r_age[j] <= '0;
                end else if (r_age[j] != AGE_MAX) begin
                    r_age[j] <= r_age[j] + AGE_W'(1);
                end
            end
            if (w_anyGrant) begin
                r_cdbValid <= 1'b1;
                r_cdbData  <= r_bufData[w_grantIdx];
                r_cdbRob   <= r_bufRob[w_grantIdx];
                r_cdbTag   <= r_bufTag[w_grantIdx];
                r_cdbSrc   <= w_grantIdx;
                if (w_grantIdx != '0) begin
                    if (w_grantIdx == SRC_W'(NUM_REQ - 1)) begin
                        r_rrPtr <= SRC_W'(1);
                    end else begin
                        r_rrPtr <= w_grantIdx + SRC_W'(1);
                    end
                end
            end else begin
                r_cdbValid <= 1'b0;
            end
        end
    end

    // Payload buffers need no reset; occupancy alone says whether they hold anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_bufData[i] <= req_data[i*DATA_W +: DATA_W];
                r_bufRob[i]  <= req_rob[i*ROB_IDX_W +: ROB_IDX_W];
                r_bufTag[i]  <= req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

    assign cdb_valid = r_cdbValid;
    assign cdb_data  = r_cdbData;
    assign cdb_rob   = r_cdbRob;
    assign cdb_tag   = r_cdbTag;
    assign cdb_src   = r_cdbSrc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for the CDB arbiter: a behavioural model of the buffers and the
// arbitration rules tracks the DUT each cycle, and directed scenarios add
// hand-computed expectations for broadcast order, latency, flush and reset.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 5;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 6;
    localparam int TAG_W   = 4;
    localparam int LIMIT   = 4;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*ROB_W-1:0]  req_rob;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic                      flush;
    logic [TAG_W-1:0]          flush_mask;
    logic                      cdb_valid;
    logic [DATA_W-1:0]         cdb_data;
    logic [ROB_W-1:0]          cdb_rob;
    logic [TAG_W-1:0]          cdb_tag;
    logic [2:0]                cdb_src;

    int checks = 0;
    int errors = 0;
    bit checkEn = 0;

    bit          mOcc [NUM_REQ];
    logic [31:0] mData[NUM_REQ];
    logic [5:0]  mRob [NUM_REQ];
    logic [3:0]  mTag [NUM_REQ];
    int          mAge [NUM_REQ];
    int          mLastLow;
    bit          mValid;
    logic [31:0] mCdbData;
    logic [5:0]  mCdbRob;
    logic [3:0]  mCdbTag;
    int          mCdbSrc;
    int          mW;
    bit          mLiveNow[NUM_REQ];
    bit          mRdy[NUM_REQ];
    int          cmpW;
    logic [4:0]  cmpRdy;

    cdb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_rob    (req_rob),
        .req_tag    (req_tag),
        .flush      (flush),
        .flush_mask (flush_mask),
        .cdb_valid  (cdb_valid),
        .cdb_data   (cdb_data),
        .cdb_rob    (cdb_rob),
        .cdb_tag    (cdb_tag),
        .cdb_src    (cdb_src)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit mLive(input int i, input logic f, input logic [3:0] m);
        return mOcc[i] && !(f && ((mTag[i] & m) != 4'b0));
    endfunction

    // Winner by the arbitration rules; -1 when nothing is eligible.
    function automatic int mWinner(input logic f, input logic [3:0] m);
        for (int j = 1; j < NUM_REQ; j++) begin
            if (mLive(j, f, m) && mAge[j] >= LIMIT) return j;
        end
        if (mLive(0, f, m)) return 0;
        for (int d = 1; d < NUM_REQ; d++) begin
            int j;
            j = ((mLastLow - 1 + d) % (NUM_REQ - 1)) + 1;
            if (mLive(j, f, m)) return j;
        end
        return -1;
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                mOcc[i] = 0;
                mAge[i] = 0;
            end
            mLastLow = NUM_REQ - 1;
            mValid   = 0;
            mCdbData = '0;
            mCdbRob  = '0;
            mCdbTag  = '0;
            mCdbSrc  = 0;
        end else begin
            mW = mWinner(flush, flush_mask);
            for (int i = 0; i < NUM_REQ; i++) begin
                mLiveNow[i] = mLive(i, flush, flush_mask);
                mRdy[i]     = !mOcc[i] || (mW == i);
            end
            if (mW >= 0) begin
                mValid   = 1;
                mCdbData = mData[mW];
                mCdbRob  = mRob[mW];
                mCdbTag  = mTag[mW];
                mCdbSrc  = mW;
            end else begin
                mValid = 0;
            end
            for (int j = 1; j < NUM_REQ; j++) begin
                if (mW == j || !mLiveNow[j]) mAge[j] = 0;
                else mAge[j] = mAge[j] + 1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && mRdy[i]) begin
                    mData[i] = req_data[i*DATA_W +: DATA_W];
                    mRob[i]  = req_rob[i*ROB_W +: ROB_W];
                    mTag[i]  = req_tag[i*TAG_W +: TAG_W];
                    mOcc[i]  = !(flush && ((req_tag[i*TAG_W +: TAG_W] & flush_mask) != 4'b0));
                end else if (mW == i) begin
                    mOcc[i] = 0;
                end else begin
                    mOcc[i] = mLiveNow[i];
                end
            end
            if (mW >= 1) mLastLow = mW;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            cmpW = mWinner(flush, flush_mask);
            for (int i = 0; i < NUM_REQ; i++) cmpRdy[i] = !mOcc[i] || (cmpW == i);
            checkOutput("model req_ready", 64'(req_ready), 64'(cmpRdy));
            checkOutput("model cdb_valid", 64'(cdb_valid), 64'(mValid));
            checkOutput("model cdb_data", 64'(cdb_data), 64'(mCdbData));
            checkOutput("model cdb_rob", 64'(cdb_rob), 64'(mCdbRob));
            checkOutput("model cdb_tag", 64'(cdb_tag), 64'(mCdbTag));
            checkOutput("model cdb_src", 64'(cdb_src), 64'(mCdbSrc));
        end
    end

    task automatic applyStimulus(input logic r, input logic [4:0] v, input logic f, input logic [3:0] m);
        @(negedge clk);
        #1;
        rst        = r;
        req_valid  = v;
        flush      = f;
        flush_mask = m;
    endtask

    task automatic setReq(input int i, input logic [31:0] d, input logic [5:0] rb, input logic [3:0] t);
        req_data[i*DATA_W +: DATA_W] = d;
        req_rob[i*ROB_W +: ROB_W]    = rb;
        req_tag[i*TAG_W +: TAG_W]    = t;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 5'b0, 1'b0, 4'b0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
    endtask

    // Directed scenarios.
    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        flush      = 1'b0;
        flush_mask = '0;
        req_data   = '0;
        req_rob    = '0;
        req_tag    = '0;
        @(negedge clk);
        checkEn = 1;

        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("reset cdb_valid", 64'(cdb_valid), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'h1f);
        checkOutput("reset cdb_src", 64'(cdb_src), 64'd0);
        checkOutput("reset cdb_data", 64'(cdb_data), 64'd0);

        setReq(2, 32'hDEADBEEF, 6'd5, 4'b0);
        applyStimulus(1'b0, 5'b00100, 1'b0, 4'b0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("single latency idle", 64'(cdb_valid), 64'd0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("single valid", 64'(cdb_valid), 64'd1);
        checkOutput("single data", 64'(cdb_data), 64'hDEADBEEF);
        checkOutput("single rob", 64'(cdb_rob), 64'd5);
        checkOutput("single src", 64'(cdb_src), 64'd2);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("single drained", 64'(cdb_valid), 64'd0);

        doReset();
        for (int i = 1; i < NUM_REQ; i++) setReq(i, 32'h1000 + i, 6'(10 + i), 4'b0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b0, 5'b11110, 1'b0, 4'b0);
            if (c >= 1) checkOutput("rr ready of grantee", 64'(req_ready[((c - 1) % 4) + 1]), 64'd1);
            if (c >= 2) begin
                checkOutput("rr valid", 64'(cdb_valid), 64'd1);
                checkOutput("rr src", 64'(cdb_src), 64'(((c - 2) % 4) + 1));
            end
        end

        doReset();
        setReq(0, 32'hB0B0B0B0, 6'd20, 4'b0);
        setReq(3, 32'hC3C3C3C3, 6'd23, 4'b0);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 5'b01001, 1'b0, 4'b0);
            if (c >= 2) begin
                checkOutput("starve valid", 64'(cdb_valid), 64'd1);
                checkOutput("starve src", 64'(cdb_src), (((c - 1) % 5) == 0) ? 64'd3 : 64'd0);
            end
        end

        doReset();
        setReq(1, 32'h11111111, 6'd1, 4'b0001);
        setReq(2, 32'h22222222, 6'd2, 4'b0010);
        applyStimulus(1'b0, 5'b00110, 1'b0, 4'b0);
        applyStimulus(1'b0, 5'b0, 1'b1, 4'b0001);
        checkOutput("flush pre valid", 64'(cdb_valid), 64'd0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush ready1", 64'(req_ready[1]), 64'd1);
        checkOutput("flush survivor valid", 64'(cdb_valid), 64'd1);
        checkOutput("flush survivor src", 64'(cdb_src), 64'd2);
        checkOutput("flush survivor data", 64'(cdb_data), 64'h22222222);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush victim absent", 64'(cdb_valid), 64'd0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush victim absent late", 64'(cdb_valid), 64'd0);

        doReset();
        setReq(4, 32'h44444444, 6'd9, 4'b0001);
        applyStimulus(1'b0, 5'b10000, 1'b1, 4'b0001);
        checkOutput("flush accept ready4", 64'(req_ready[4]), 64'd1);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush accept dropped ready", 64'(req_ready), 64'h1f);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush accept no bcast", 64'(cdb_valid), 64'd0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("flush accept no bcast late", 64'(cdb_valid), 64'd0);

        doReset();
        setReq(1, 32'hA1, 6'd11, 4'b0);
        setReq(2, 32'hA2, 6'd12, 4'b0);
        setReq(3, 32'hA3, 6'd13, 4'b0);
        setReq(4, 32'hA4, 6'd14, 4'b0);
        applyStimulus(1'b0, 5'b01110, 1'b0, 4'b0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        applyStimulus(1'b1, 5'b0, 1'b0, 4'b0);
        checkOutput("prereset src", 64'(cdb_src), 64'd1);
        applyStimulus(1'b0, 5'b10010, 1'b0, 4'b0);
        checkOutput("midrst valid", 64'(cdb_valid), 64'd0);
        checkOutput("midrst ready", 64'(req_ready), 64'h1f);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("postrst latency", 64'(cdb_valid), 64'd0);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("postrst first valid", 64'(cdb_valid), 64'd1);
        checkOutput("postrst first src", 64'(cdb_src), 64'd1);
        checkOutput("postrst first data", 64'(cdb_data), 64'hA1);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("postrst second src", 64'(cdb_src), 64'd4);
        checkOutput("postrst second data", 64'(cdb_data), 64'hA4);
        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        checkOutput("postrst idle", 64'(cdb_valid), 64'd0);

        applyStimulus(1'b0, 5'b0, 1'b0, 4'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Registered arbiter that shares the single common data bus (CDB) among the execution units (compare/branch, multiply, divide, load/store, ALU). Each unit hands a result over a valid/ready handshake into a one-entry holding buffer. Every cycle the arbiter picks one buffered result: the branch/compare requester has fixed high priority, the rest are served round-robin, and an aging counter prevents starvation. The winner is broadcast from an output register to the ROB and reservation stations. Entries on a squashed speculative path are dropped on flush.

## Interface
- NUM_REQ, 5, number of requesters; index 0 is the high-priority (compare/branch) port
- DATA_W, 32, result width
- ROB_IDX_W, 6, ROB index width
- TAG_W, 4, branch-tag bit-vector width
- STARVE_LIMIT, 4, age at which a waiting low-priority entry overrides index 0
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester result valid
- req_ready  out  NUM_REQ  per-requester buffer can accept
- req_data  in  NUM_REQ*DATA_W  results, requester i at [i*DATA_W +: DATA_W]
- req_rob  in  NUM_REQ*ROB_IDX_W  destination ROB indices, same packing
- req_tag  in  NUM_REQ*TAG_W  branch tags, same packing
- flush  in  1  squash request
- flush_mask  in  TAG_W  tag bits being squashed (valid when flush=1)
- cdb_valid  out  1  broadcast valid
- cdb_data  out  DATA_W  broadcast result
- cdb_rob  out  ROB_IDX_W  broadcast ROB index
- cdb_tag  out  TAG_W  broadcast branch tag
- cdb_src  out  clog2(NUM_REQ)  index of the winning requester

## Operation
- State: per-requester occ bit plus a data/rob/tag buffer; per-requester age counter, width clog2(STARVE_LIMIT+1), saturating; rr_ptr over 1..NUM_REQ-1; output register.
- Reset: occ=0, age=0, rr_ptr=1, cdb_valid=0, cdb_data/rob/tag/src=0.
- Live entry i: occ[i] && !(flush && |(buf_tag[i] & flush_mask)).
- Grant (combinational from state and flush only, never from req_valid):
  - If any live entry j≥1 has age[j]==STARVE_LIMIT, grant the lowest such j.
  - Else, if entry 0 is live, grant 0.
  - Else grant the first live j≥1 scanning upward from rr_ptr with wrap (NUM_REQ-1 wraps to 1).
  - Else no grant.
- req_ready[i] = !occ[i] || grant[i]. A buffer granted this cycle accepts a new result in the same cycle.
- Accept: req_valid[i] && req_ready[i] writes the buffer and sets occ[i]. If flush && |(req_tag[i] & flush_mask), the result is accepted and discarded, and occ[i] stays clear unless it was already set and not granted.
- Flush clears occ for every matching buffer in the same edge. Matching buffers are never granted.
- On a grant to g: the output register loads buf[g] with cdb_src=g and cdb_valid=1, occ[g] is cleared unless refilled, age[g]=0, and if g≥1 then rr_ptr=g+1 (wrapped).
- With no grant: cdb_valid=0 next cycle. The other cdb_* fields hold their values.
- Age: every live, ungranted entry j≥1 increments (saturating). Empty or flushed entries reset to 0. age[0] is unused.
- A value already in the output register is not retracted by a later flush. Squashing it is the consumer's job via cdb_tag.
- If rst and flush are both high, rst wins.

## Timing
- Result accepted at edge N; earliest cdb_valid is after edge N+1 (2-cycle latency).
- Sustained throughput is one broadcast per cycle. A single requester can stream every cycle via the same-cycle refill.
- Any live low-priority entry waits at most STARVE_LIMIT cycles plus the ahead-of-it starved entries.
- Reset takes effect at the next edge. All buffered results are dropped and cdb_valid=0 at the following cycle.

## Test plan
- Idle bus; req_valid[2]=1 with data 0xDEADBEEF, rob 5 at edge 0 -> cdb_valid=1, cdb_data=0xDEADBEEF, cdb_rob=5, cdb_src=2 after edge 1; cdb_valid=0 after edge 2.
- req_valid[1..4] held high with distinct data, req 0 idle -> cdb_src sequence 1,2,3,4,1,…; req_ready[i] is high in the cycle it is granted; no bubbles.
- req 0 and req 3 both continuously valid -> src 0 for 4 consecutive broadcasts, then src 3 once (age hit 4), then 0 again.
- Buffers 1 (tag 0b0001) and 2 (tag 0b0010) occupied; flush=1, flush_mask=0b0001 -> buffer 1 is never broadcast and req_ready[1]=1 next cycle; buffer 2 is broadcast.
- Flush coinciding with a new accept of tag 0b0001 on req 4 -> req_ready[4]=1, entry dropped, nothing from src 4 ever appears.
- Three buffers full, rst asserted for one cycle -> cdb_valid=0, all req_ready=1, rr_ptr=1; the next single request is broadcast with 2-cycle latency.
